// File: rtl/id_ex_stage_pkg.sv
// Shared types and defaults for the ID/EX pipeline register and its forwarding muxes.
package id_ex_stage_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 4;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats register file.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              ex_valid_i,
  input  logic              rs_used_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic     exmem_hit;
  logic     memwb_hit;
  fwd_sel_e sel;

  // Register 0 is hard-wired to zero, so a write to it must never be forwarded.
  assign exmem_hit = ex_valid_i & rs_used_i & exmem_reg_write_i &
                     (exmem_rd_i != '0) & (exmem_rd_i == rs_i);
  assign memwb_hit = ex_valid_i & rs_used_i & memwb_reg_write_i &
                     (memwb_rd_i != '0) & (memwb_rd_i == rs_i);

  always_comb begin
    // NOTE: default assignment first on every path keeps this combinational (no latch).
    sel = FWD_RF;
    if (exmem_hit)      sel = FWD_EXMEM;
    else if (memwb_hit) sel = FWD_MEMWB;
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (sel)
      FWD_EXMEM: data_o = exmem_result_i;
      FWD_MEMWB: data_o = memwb_data_i;
      default:   data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB forwarding and load-use detect.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_alu_src_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              load_use_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rs1_used;
    logic              rs2_used;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (!stall_i) begin
      ex_d.valid      = id_valid_i;
      ex_d.rs1        = id_rs1_i;
      ex_d.rs2        = id_rs2_i;
      ex_d.rd         = id_rd_i;
      ex_d.rs1_used   = id_rs1_used_i;
      ex_d.rs2_used   = id_rs2_used_i;
      ex_d.rs1_data   = id_rs1_data_i;
      ex_d.rs2_data   = id_rs2_data_i;
      ex_d.imm        = id_imm_i;
      ex_d.alu_src    = id_alu_src_i;
      ex_d.alu_ctrl   = id_alu_ctrl_i;
      ex_d.reg_write  = id_reg_write_i  & id_valid_i;
      ex_d.mem_read   = id_mem_read_i   & id_valid_i;
      ex_d.mem_write  = id_mem_write_i  & id_valid_i;
      ex_d.mem_to_reg = id_mem_to_reg_i & id_valid_i;
    end
  end

  // NOTE: non-blocking assignment for state; the async reset clears the whole slot at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
    .ex_valid_i        (ex_q.valid),
    .rs_used_i         (ex_q.rs1_used),
    .rs_i              (ex_q.rs1),
    .rf_data_i         (ex_q.rs1_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_o            (rs1_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
    .ex_valid_i        (ex_q.valid),
    .rs_used_i         (ex_q.rs2_used),
    .rs_i              (ex_q.rs2),
    .rf_data_i         (ex_q.rs2_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_o            (rs2_fwd)
  );

  assign alu_src1_o      = rs1_fwd;
  assign alu_src2_o      = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign store_data_o    = rs2_fwd;
  assign alu_ctrl_o      = ex_q.alu_ctrl;
  assign ex_rd_o         = ex_q.rd;
  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;

  // A load in EX cannot forward its data to the instruction now in ID.
  assign load_use_o = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid_i &
                      (((ex_q.rd == id_rs1_i) & id_rs1_used_i) |
                       ((ex_q.rd == id_rs2_i) & id_rs2_used_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX-slot contents, checked after each edge.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic        id_alu_src_i;
  logic [3:0]  id_alu_ctrl_i;
  logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [63:0] exmem_result_i, memwb_data_i;
  logic [63:0] alu_src1_o, alu_src2_o, store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
  logic        load_use_o;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_alu_src_i(id_alu_src_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .load_use_o(load_use_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [63:0] src1, src2, store;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        valid, rw, mr, mw, m2r;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input string tag, input logic [63:0] src1, input logic [63:0] src2,
                              input logic [63:0] store, input logic [3:0] ctrl, input logic [4:0] rd,
                              input logic valid, input logic rw, input logic mr, input logic mw,
                              input logic m2r);
    exp_t e;
    e.tag = tag; e.src1 = src1; e.src2 = src2; e.store = store; e.ctrl = ctrl; e.rd = rd;
    e.valid = valid; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check({e.tag, ".src1"},  alu_src1_o,             e.src1);
    check({e.tag, ".src2"},  alu_src2_o,             e.src2);
    check({e.tag, ".store"}, store_data_o,           e.store);
    check({e.tag, ".ctrl"},  64'(alu_ctrl_o),        64'(e.ctrl));
    check({e.tag, ".rd"},    64'(ex_rd_o),           64'(e.rd));
    check({e.tag, ".valid"}, 64'(ex_valid_o),        64'(e.valid));
    check({e.tag, ".ctl"},
          64'({ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}),
          64'({e.rw, e.mr, e.mw, e.m2r}));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard: observed empty queue required an entry");
    end else begin
      compare(sb.pop_front());
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [63:0] d1,
                          input logic [4:0] rs2, input logic u2, input logic [63:0] d2,
                          input logic [4:0] rd, input logic [63:0] imm, input logic asrc,
                          input logic [3:0] ctrl, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
    id_valid_i = v; id_rs1_i = rs1; id_rs1_used_i = u1; id_rs1_data_i = d1;
    id_rs2_i = rs2; id_rs2_used_i = u2; id_rs2_data_i = d2; id_rd_i = rd; id_imm_i = imm;
    id_alu_src_i = asrc; id_alu_ctrl_i = ctrl;
    id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw; id_mem_to_reg_i = m2r;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [63:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [63:0] mdat);
    exmem_reg_write_i = ew; exmem_rd_i = erd; exmem_result_i = eres;
    memwb_reg_write_i = mw; memwb_rd_i = mrd; memwb_data_i = mdat;
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    compare(mk("reset", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    check("reset.load_use", 64'(load_use_o), 64'(1'b0));
    @(negedge clk_i);
    rst_i = 1'b1;

    // Plain ADD, no forwarding hits
    drive_id(1, 5'd3, 1, 64'd5, 5'd4, 1, 64'd7, 5'd5, 64'h0, 0, 4'b0010, 1, 0, 0, 0);
    sb.push_back(mk("add", 64'd5, 64'd7, 64'd7, 4'b0010, 5'd5, 1, 1, 0, 0, 0));
    step();

    // Both paths hit rs1: EX/MEM wins, then MEM/WB once EX/MEM stops writing
    set_fwd(1, 5'd3, 64'h100, 1, 5'd3, 64'h200);
    #1 check("fwd_exmem.src1", alu_src1_o, 64'h100);
    check("fwd_exmem.src2", alu_src2_o, 64'd7);
    exmem_reg_write_i = 1'b0;
    #1 check("fwd_memwb.src1", alu_src1_o, 64'h200);

    // Register 0 is never forwarded
    set_fwd(1, 5'd0, 64'hFFFF, 1, 5'd0, 64'hFFFF);
    drive_id(1, 5'd0, 1, 64'd0, 5'd4, 1, 64'd7, 5'd1, 64'h0, 0, 4'b0000, 1, 0, 0, 0);
    sb.push_back(mk("x0", 64'd0, 64'd7, 64'd7, 4'b0000, 5'd1, 1, 1, 0, 0, 0));
    step();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load into EX, then probe load-use against the instruction in ID
    drive_id(1, 5'd1, 1, 64'h1000, 5'd0, 0, 64'd0, 5'd6, 64'd16, 1, 4'b0010, 1, 1, 0, 1);
    sb.push_back(mk("load", 64'h1000, 64'd16, 64'd0, 4'b0010, 5'd6, 1, 1, 1, 0, 1));
    step();
    drive_id(1, 5'd2, 1, 64'd0, 5'd6, 1, 64'd0, 5'd7, 64'h0, 0, 4'b0110, 1, 0, 0, 0);
    #1 check("load_use.rs2", 64'(load_use_o), 64'(1'b1));
    id_rs2_used_i = 1'b0;
    #1 check("load_use.unused", 64'(load_use_o), 64'(1'b0));
    id_rs2_used_i = 1'b1; id_valid_i = 1'b0;
    #1 check("load_use.invalid", 64'(load_use_o), 64'(1'b0));
    id_valid_i = 1'b1; id_rs2_i = 5'd9; id_rs1_i = 5'd6;
    #1 check("load_use.rs1", 64'(load_use_o), 64'(1'b1));

    // Capture an OR, then stall twice with changing ID inputs
    drive_id(1, 5'd7, 1, 64'h11, 5'd8, 1, 64'h22, 5'd9, 64'h0, 0, 4'b0001, 1, 0, 0, 0);
    sb.push_back(mk("or", 64'h11, 64'h22, 64'h22, 4'b0001, 5'd9, 1, 1, 0, 0, 0));
    step();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_id(1, 5'(10 + i), 1, 64'(32'hDEAD0000 + i), 5'(12 + i), 1, 64'hBEEF, 5'(20 + i),
               64'h55, 1, 4'b0111, 0, 1, 1, 1);
      sb.push_back(mk("stall", 64'h11, 64'h22, 64'h22, 4'b0001, 5'd9, 1, 1, 0, 0, 0));
      step();
    end

    // Flush has priority over stall
    flush_i = 1'b1;
    sb.push_back(mk("flush", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    step();
    flush_i = 1'b0; stall_i = 1'b0;

    // Store: immediate to ALU, forwarded rs2 to store data
    set_fwd(0, 0, 0, 1, 5'd5, 64'hAB);
    drive_id(1, 5'd1, 1, 64'h40, 5'd5, 1, 64'h99, 5'd0, 64'd8, 1, 4'b0010, 0, 0, 1, 0);
    sb.push_back(mk("sw", 64'h40, 64'd8, 64'hAB, 4'b0010, 5'd0, 1, 0, 0, 1, 0));
    step();

    // Async reset mid-cycle clears everything immediately
    #3 rst_i = 1'b0;
    #1 compare(mk("async_rst", 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);
    rst_i = 1'b1;
    set_fwd(0, 0, 0, 0, 0, 0);
    drive_id(1, 5'd2, 1, 64'h30, 5'd3, 1, 64'h10, 5'd4, 64'h0, 0, 4'b0110, 1, 0, 0, 0);
    sb.push_back(mk("post_rst", 64'h30, 64'h10, 64'h10, 4'b0110, 5'd4, 1, 1, 0, 0, 0));
    step();

    check("scoreboard.drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
